// File: rtl/ex_muldiv_unit_if.sv
// Port bundle for the EX-stage multiply/divide unit.
// The pipeline side uses the master modport. The unit uses the slave modport.
interface ex_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, op, a, b, flush, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, flush, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO. The result lands DATA_W+1 edges after start.
// There is no backpressure: busy freezes the front of the pipeline, and start/MTHI/MTLO are ignored while busy.
module ex_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_unit_if.slave mdu
);
  localparam int               CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;

  logic                accept;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_trial;
  logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
  logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix;

  assign accept = (state_q == IDLE) && mdu.start && !mdu.flush;
  assign a_neg  = !mdu.op[0] && mdu.a[DATA_W-1];
  assign b_neg  = !mdu.op[0] && mdu.b[DATA_W-1];
  assign a_abs  = a_neg ? -mdu.a : mdu.a;
  assign b_abs  = b_neg ? -mdu.b : mdu.b;

  // Multiply: the upper half accumulates the multiplicand, and the lower half holds the remaining multiplier bits.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: the upper half is the partial remainder, and the lower half shifts dividend bits out and quotient bits in.
  assign div_trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, opb_q};
  assign div_next  = div_trial[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                       : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[DATA_W-1:0];
  assign rem      = acc_q[2*DATA_W-1:DATA_W];
  // With a zero divisor the remainder has already collapsed to |a|, so re-signing it gives back a.
  assign quo_fix  = (opb_q == '0) ? '1 : (neg_q ? -quo : quo);
  assign rem_fix  = rneg_q ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (mdu.flush) state_d = IDLE;
               else if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mdu.flush && mdu.hi_we) hi_d = mdu.wdata;
        if (!mdu.flush && mdu.lo_we) lo_d = mdu.wdata;
        if (accept) begin
          is_div_d = mdu.op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = '0;
          acc_d    = {{DATA_W{1'b0}}, (mdu.op[1] ? a_abs : b_abs)};
          opb_d    = mdu.op[1] ? b_abs : a_abs;
        end
      end
      CALC: begin
        if (!mdu.flush) begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = is_div_q ? div_next : mul_next;
        end
      end
      FIX: begin
        if (!mdu.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mdu.busy = (state_q != IDLE);
    mdu.done = done_q;
    mdu.hi   = hi_q;
    mdu.lo   = lo_q;
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit. It uses directed cases and random cases.
// Expected values come from an arithmetic reference model.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_muldiv_unit_if #(.DATA_W(W)) mdu_if ();

  ex_muldiv_unit #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mdu_if.start = 1'b0;
    mdu_if.op    = 2'd0;
    mdu_if.a     = '0;
    mdu_if.b     = '0;
    mdu_if.flush = 1'b0;
    mdu_if.hi_we = 1'b0;
    mdu_if.lo_we = 1'b0;
    mdu_if.wdata = '0;
  endtask

  // Presents start for one edge, then scrambles the operands.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_if.start = 1'b1;
    mdu_if.op    = op;
    mdu_if.a     = a;
    mdu_if.b     = b;
    tick();
    mdu_if.start = 1'b0;
    mdu_if.a     = $urandom;
    mdu_if.b     = $urandom;
    mdu_if.op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = mdu_if.busy ? 1 : 0;
    while (!mdu_if.done && lat < 60) begin
      tick();
      lat++;
      if (mdu_if.busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", mdu_if.busy); end
    checks++; if (mdu_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", mdu_if.done); end
    checks++; if (mdu_if.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", mdu_if.lo); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu_max();
    int lat, bc;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got=%0d want=33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got=%0d want=33", bc); end
    checks++; if (mdu_if.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h want=fffffffe", mdu_if.hi); end
    checks++; if (mdu_if.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h want=00000001", mdu_if.lo); end
    tick();
    checks++; if (mdu_if.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b want=0", mdu_if.done); end
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL idle_after_done got=%b want=0", mdu_if.busy); end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [4] = '{2'd0, 2'd2, 2'd2, 2'd3};
    logic [31:0] t_a  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [31:0] t_b  [4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_hi [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd5};
    logic [31:0] t_lo [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(lat, bc);
      checks++; if (lat !== 33) begin errors++; $display("FAIL directed%0d_latency got=%0d want=33", i, lat); end
      checks++; if (mdu_if.hi !== t_hi[i]) begin errors++; $display("FAIL directed%0d_hi got=%h want=%h", i, mdu_if.hi, t_hi[i]); end
      checks++; if (mdu_if.lo !== t_lo[i]) begin errors++; $display("FAIL directed%0d_lo got=%h want=%h", i, mdu_if.lo, t_lo[i]); end
    end
  endtask

  task automatic test_random_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      exp = model(op, a, b);
      issue(op, a, b);
      wait_done(lat, bc);
      checks++;
      if ({mdu_if.hi, mdu_if.lo} !== exp || lat !== 33) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h got=%h_%h lat=%0d want=%h_%h lat=33",
                 i, op, a, b, mdu_if.hi, mdu_if.lo, lat, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_flush();
    int lat, bc;
    bit seen_done;
    mdu_if.hi_we = 1'b1; mdu_if.wdata = 32'h11; tick();
    mdu_if.hi_we = 1'b0; mdu_if.lo_we = 1'b1; mdu_if.wdata = 32'h22; tick();
    mdu_if.lo_we = 1'b0;
    checks++; if (mdu_if.hi !== 32'h11 || mdu_if.lo !== 32'h22) begin errors++; $display("FAIL mthi_mtlo got=%h/%h want=11/22", mdu_if.hi, mdu_if.lo); end
    mdu_if.flush = 1'b1; mdu_if.hi_we = 1'b1; mdu_if.wdata = 32'h99; tick();
    mdu_if.flush = 1'b0; mdu_if.hi_we = 1'b0;
    checks++; if (mdu_if.hi !== 32'h11 || mdu_if.busy !== 1'b0) begin errors++; $display("FAIL flush_blocks_mthi got hi=%h busy=%b want hi=11 busy=0", mdu_if.hi, mdu_if.busy); end
    mdu_if.flush = 1'b1;
    issue(2'd3, 32'd100, 32'd7);
    mdu_if.flush = 1'b0;
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start got busy=%b want=0", mdu_if.busy); end
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) tick();
    mdu_if.flush = 1'b1;
    tick();
    mdu_if.flush = 1'b0;
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL flush_calc_busy got=%b want=0", mdu_if.busy); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mdu_if.done) seen_done = 1'b1;
      tick();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL flush_calc_done got=%b want=0", seen_done); end
    checks++; if (mdu_if.hi !== 32'h11 || mdu_if.lo !== 32'h22) begin errors++; $display("FAIL flush_calc_hilo got=%h/%h want=11/22", mdu_if.hi, mdu_if.lo); end
    repeat (5) tick();
    issue(2'd3, 32'd100, 32'd7);
    wait_done(lat, bc);
    checks++; if (mdu_if.lo !== 32'd14 || mdu_if.hi !== 32'd2) begin errors++; $display("FAIL after_flush_divu got=%h/%h want=2/e", mdu_if.hi, mdu_if.lo); end
    issue(2'd0, 32'd123, 32'hFFFF_FFFB);
    repeat (32) tick();
    checks++; if (mdu_if.busy !== 1'b1) begin errors++; $display("FAIL fix_state_busy got=%b want=1", mdu_if.busy); end
    mdu_if.flush = 1'b1;
    tick();
    mdu_if.flush = 1'b0;
    checks++; if (mdu_if.done !== 1'b0 || mdu_if.busy !== 1'b0) begin errors++; $display("FAIL flush_fix got done=%b busy=%b want 0/0", mdu_if.done, mdu_if.busy); end
    checks++; if (mdu_if.hi !== 32'd2 || mdu_if.lo !== 32'd14) begin errors++; $display("FAIL flush_fix_hilo got=%h/%h want=2/e", mdu_if.hi, mdu_if.lo); end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] exp;
    int lat, bc;
    exp = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) tick();
    mdu_if.start = 1'b1; mdu_if.op = 2'd2; mdu_if.a = $urandom; mdu_if.b = 32'd7;
    mdu_if.hi_we = 1'b1; mdu_if.lo_we = 1'b1; mdu_if.wdata = 32'hDEAD;
    tick();
    clear_inputs();
    wait_done(lat, bc);
    checks++; if (lat !== 27) begin errors++; $display("FAIL busy_ignore_latency got=%0d want=27", lat); end
    checks++; if ({mdu_if.hi, mdu_if.lo} !== exp) begin errors++; $display("FAIL busy_ignore_result got=%h_%h want=%h_%h", mdu_if.hi, mdu_if.lo, exp[63:32], exp[31:0]); end
    tick();
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_restart got=%b want=0", mdu_if.busy); end
    mdu_if.hi_we = 1'b1; mdu_if.lo_we = 1'b1; mdu_if.wdata = 32'hCAFE_F00D;
    tick();
    clear_inputs();
    checks++; if (mdu_if.hi !== 32'hCAFE_F00D || mdu_if.lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_we got=%h/%h want=cafef00d", mdu_if.hi, mdu_if.lo); end
    mdu_if.hi_we = 1'b1; mdu_if.wdata = 32'h5555;
    issue(2'd3, 32'd50, 32'd6);
    mdu_if.hi_we = 1'b0;
    checks++; if (mdu_if.hi !== 32'h5555 || mdu_if.busy !== 1'b1) begin errors++; $display("FAIL we_with_start got hi=%h busy=%b want 5555/1", mdu_if.hi, mdu_if.busy); end
    wait_done(lat, bc);
    checks++; if (mdu_if.hi !== 32'd2 || mdu_if.lo !== 32'd8) begin errors++; $display("FAIL we_with_start_result got=%h/%h want=2/8", mdu_if.hi, mdu_if.lo); end
  endtask

  task automatic test_async_reset();
    logic [63:0] exp;
    int lat, bc;
    issue(2'd1, 32'hFFFF_0000, 32'h0001_0001);
    repeat (19) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) begin errors++; $display("FAIL async_rst_ctrl got busy=%b done=%b want 0/0", mdu_if.busy, mdu_if.done); end
    checks++; if (mdu_if.hi !== 32'd0 || mdu_if.lo !== 32'd0) begin errors++; $display("FAIL async_rst_hilo got=%h/%h want=0/0", mdu_if.hi, mdu_if.lo); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) begin errors++; $display("FAIL post_rst_idle got busy=%b done=%b want 0/0", mdu_if.busy, mdu_if.done); end
    exp = model(2'd2, 32'hFFFF_FF9C, 32'd9);
    issue(2'd2, 32'hFFFF_FF9C, 32'd9);
    wait_done(lat, bc);
    checks++; if ({mdu_if.hi, mdu_if.lo} !== exp || lat !== 33) begin errors++; $display("FAIL post_rst_div got=%h_%h lat=%0d want=%h_%h lat=33", mdu_if.hi, mdu_if.lo, lat, exp[63:32], exp[31:0]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_multu_max();
    test_directed();
    test_random_back_to_back();
    test_flush();
    test_busy_ignore();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and serves MTHI/MTLO writes.
- Drives `busy` so the hazard unit can freeze IF/ID/EX on a dependent MFHI/MFLO, MTHI/MTLO or mult/div while the EX-to-MEM register keeps advancing.

Parameters:
- DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  DATA_W  rs operand (dividend / multiplicand)
- b  in  DATA_W  rt operand (divisor / multiplier)
- flush  in  1  synchronous abort (the pipeline CLR for EX)
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  DATA_W  MTHI/MTLO data
- busy  out  1  high in any state other than IDLE
- done  out  1  registered one-cycle pulse when HI/LO take a result
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset (async, any state):
  - state=IDLE, hi=lo=0, done=0, iteration counter=0, internal datapath regs=0.
  - Reset mid-operation discards the operation with no done.
- States: IDLE, CALC, FIX.
- IDLE with start=1 and flush=0, at the edge:
  - Latch op.
  - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Latch result signs: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - Clear counter; go to CALC.
- CALC: one iteration per cycle; after the DATA_W-th iteration go to FIX.
  - Multiply: shift-add on a 2*DATA_W accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIX edge:
  - Apply sign correction (two's-complement negate where the sign bit is set).
  - Write hi/lo, set done=1 for exactly one cycle, return to IDLE.
- Latency: start accepted at edge 0; result in hi/lo after edge DATA_W+1 (33). busy is high for 33 cycles.
- Result mapping:
  - Multiply: {hi,lo} = full 2*DATA_W product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b=0, either signedness): hi=a, lo=all ones. Sign fixup is skipped.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0. This is the natural result; no special case is needed.
- Operands a/b are consumed only at the start edge; later changes have no effect.
- start while busy: ignored. The hazard unit guarantees this cannot happen; the bench checks that it is ignored.
- flush:
  - In CALC or FIX, aborts at the next edge: go to IDLE, hi/lo unchanged, no done.
  - flush and start together in IDLE: flush wins and nothing starts.
  - flush in IDLE with no start: no effect.
- hi_we / lo_we:
  - Honoured only in IDLE with flush=0; ignored while busy.
  - Both asserted: both HI and LO take wdata.
  - hi_we and start in the same IDLE cycle: the write occurs and the operation also starts; its later result overwrites the written value.
- done deasserts on the edge after it is set.
- busy is combinational from state only (not from start).

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; done at edge 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO; start DIVU 100/7; assert flush in CALC cycle 10 -> busy low next edge, done never pulses, hi=0x11, lo=0x22; a second start 5 cycles later completes normally (lo=14, hi=2).
- During a busy MULTU, pulse start with new operands and hi_we=1, wdata=0xDEAD -> both ignored; the original product lands unchanged.
- Assert rst asynchronously (mid-cycle) in CALC cycle 20 -> busy, done, hi, lo are 0 immediately; after release, IDLE accepts a new start.
